piksel_paketleyici: RTL and testbench
=====================================

Name: piksel_paketleyici

Overview:
Downstream stage of the convolution unit. It consumes that unit's unstalled 8-bit pixel stream (veri_etkin/veri) and packs 4 consecutive pixels into 32-bit words. Words are buffered in a FIFO and presented on a valid/ready interface toward the memory writer. The block tracks the pixel position within the GENISLIK x YUKSEKLIK frame, flags the last word of each frame, and reports FIFO overflow, because the upstream stage cannot be back-pressured.

Parameters:
GENISLIK, 320, pixels per line.
YUKSEKLIK, 240, lines per frame. GENISLIK*YUKSEKLIK must be a multiple of 4.
FIFO_DERINLIK, 16, FIFO depth in 32-bit words. Must be a power of 2 and at least 2.

Ports:
clk_i  input  1  clock; all logic on the rising edge
rst_i  input  1  reset, synchronous, active-high
veri_etkin_i  input  1  pixel valid; one pixel accepted per cycle when high; no ready back to the source
veri_i  input  8  pixel value
paket_gecerli_o  output  1  output word valid
paket_o  output  32  packed word; earliest pixel in [7:0], latest in [31:24]
paket_son_o  output  1  qualifies paket_o as the last word of a frame
paket_hazir_i  input  1  consumer ready
doluluk_o  output  $clog2(FIFO_DERINLIK)+1  current FIFO word count
tasma_o  output  1  sticky overflow flag
cerceve_bitti_o  output  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset (rst_i=1 at a clock edge), including mid-operation:
  - partial word discarded, byte index cleared to 0;
  - FIFO emptied, pixel counter cleared to 0;
  - paket_gecerli_o=0, paket_o=0, paket_son_o=0, doluluk_o=0, tasma_o=0, cerceve_bitti_o=0.
- Packing:
  - 2-bit byte index; each accepted pixel is written to byte lane [index*8 +: 8] of the assembly register, then the index increments.
  - On the 4th pixel (index=3), the completed word {veri_i, lane2, lane1, lane0} is pushed into the FIFO at the same edge, and the index wraps to 0.
- Frame position:
  - Pixel counter runs 0..GENISLIK*YUKSEKLIK-1 and increments on every accepted pixel, including pixels of dropped words.
  - When the pixel with counter = last accepted: counter wraps to 0; cerceve_bitti_o=1 for the following cycle only; the word pushed at that edge carries son=1 (stored as a 33rd FIFO bit). All other words carry son=0.
- FIFO:
  - Synchronous, with registered outputs.
  - A word pushed at edge N is visible on paket_gecerli_o/paket_o no earlier than the cycle after edge N. There is no same-cycle bypass.
  - paket_gecerli_o = FIFO not empty.
  - paket_o/paket_son_o show the head entry.
- Handshake:
  - A transfer occurs on any edge with paket_gecerli_o & paket_hazir_i; the head is popped.
  - While valid and not ready, paket_o and paket_son_o hold stable.
  - paket_gecerli_o never drops without a transfer, except on reset.
- Simultaneous push and pop:
  - Both take effect; doluluk_o is unchanged.
  - When full, a push accompanied by a pop in the same cycle is accepted (no overflow).
  - When empty, a push plus ready does not pop the new word in that cycle.
- Overflow:
  - A push when doluluk_o=FIFO_DERINLIK and no pop drops the word.
  - tasma_o is set and held until reset.
  - FIFO contents and pointers are unchanged.
  - Frame and byte counters continue, so later words keep their alignment.
- Pointers are $clog2(FIFO_DERINLIK) bits and wrap naturally. doluluk_o is held in a dedicated counter: +1 on push only, -1 on pop only.
- veri_etkin_i=0: nothing changes except pops. Gaps between pixels are allowed anywhere, including mid-word.

Test Plan:
- Reset, then pixels 0x11,0x22,0x33,0x44 on 4 consecutive cycles with paket_hazir_i=1:
  - paket_gecerli_o=1 with paket_o=0x44332211 in the cycle after the 4th pixel edge;
  - popped at the next edge; doluluk_o returns to 0; paket_son_o=0.
- paket_hazir_i=0, 68 pixels with values 0..67:
  - doluluk_o reaches 16 after the 16th word; tasma_o=1 after the 17th word;
  - draining yields exactly 16 words, first 0x03020100, last 0x3F3E3D3C.
- Full frame of 76800 pixels, value = index mod 256, paket_hazir_i=1:
  - exactly 19200 words; only the final word has paket_son_o=1, equal to 0xFFFEFDFC;
  - cerceve_bitti_o pulses once; tasma_o stays 0.
- paket_hazir_i toggling pseudo-randomly with continuous input:
  - paket_o stable whenever valid&!ready;
  - no word lost or duplicated with the FIFO never full (scoreboard).
- FIFO full (16 words) and a 4th pixel arriving in the same cycle as paket_hazir_i=1:
  - word accepted; doluluk_o stays 16; tasma_o stays 0.
- rst_i asserted for 1 cycle after 2 pixels (0xAA, 0xBB):
  - all outputs go to 0;
  - following pixels 1,2,3,4 produce 0x04030201;
  - the frame counter restarts, so son appears after 76800 more pixels.

Source files
------------

// File: rtl/piksel_paketleyici.sv
// piksel_paketleyici
// Packs the convolution unit's unstalled 8-bit pixel stream into 32-bit words
// (earliest pixel in [7:0]). Finished words go through a small FIFO to a
// valid/ready consumer. The block tracks frame position, tags the last word
// of each frame, and flags FIFO overflow because the source cannot be stalled.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   veri_etkin_i     pixel valid (no back-pressure toward the source)
//   veri_i           pixel value
//   paket_gecerli_o  FIFO head valid (FIFO not empty)
//   paket_o          FIFO head word
//   paket_son_o      head word is the last word of a frame
//   paket_hazir_i    consumer ready; transfer when valid & ready
//   doluluk_o        FIFO word count
//   tasma_o          sticky overflow flag (a word was dropped)
//   cerceve_bitti_o  one-cycle pulse after the last pixel of a frame
//
// GENISLIK*YUKSEKLIK must be a multiple of 4 so that every frame ends on a
// word boundary. FIFO_DERINLIK must be a power of 2, at least 2.

module piksel_paketleyici #(
  parameter int GENISLIK      = 320,
  parameter int YUKSEKLIK     = 240,
  parameter int FIFO_DERINLIK = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             veri_etkin_i,
  input  logic [7:0]                       veri_i,
  output logic                             paket_gecerli_o,
  output logic [31:0]                      paket_o,
  output logic                             paket_son_o,
  input  logic                             paket_hazir_i,
  output logic [$clog2(FIFO_DERINLIK):0]   doluluk_o,
  output logic                             tasma_o,
  output logic                             cerceve_bitti_o
);

  localparam int PIKSEL_SAYISI = GENISLIK * YUKSEKLIK;
  localparam int CW            = $clog2(PIKSEL_SAYISI);
  localparam int AW            = $clog2(FIFO_DERINLIK);

  localparam logic [CW-1:0] SON_PIKSEL = CW'(PIKSEL_SAYISI - 1);
  localparam logic [AW:0]   DERINLIK   = (AW + 1)'(FIFO_DERINLIK);

  // Packing state. Only lanes 0..2 are stored: lane 3 goes straight from
  // veri_i into the FIFO on the same edge.
  logic [1:0]    bayt_idx;
  logic [23:0]   toplama;
  logic [CW-1:0] piksel_say;
  logic          cerceve_q;
  logic          tasma_q;

  // FIFO storage; bit 32 is the end-of-frame tag.
  logic [32:0]   mem [FIFO_DERINLIK];
  logic [AW-1:0] yaz_ptr;
  logic [AW-1:0] oku_ptr;
  logic [AW:0]   doluluk_q;
  logic [32:0]   bas_q;

  logic          yaz;
  logic          yaz_ok;
  logic          oku;
  logic          dolu;
  logic          son_piksel;
  logic [32:0]   yaz_veri;
  logic [AW-1:0] oku_ptr_sonraki;
  logic [AW:0]   doluluk_sonraki;
  logic [32:0]   bas_sonraki;

  always_comb begin
    yaz        = veri_etkin_i && (bayt_idx == 2'd3);
    son_piksel = (piksel_say == SON_PIKSEL);
    yaz_veri   = {son_piksel, veri_i, toplama};
    oku        = (doluluk_q != '0) && paket_hazir_i;
    dolu       = (doluluk_q == DERINLIK);
    // When full, a push is still taken if the head leaves on the same edge.
    yaz_ok     = yaz && (!dolu || oku);

    oku_ptr_sonraki = oku ? (oku_ptr + AW'(1)) : oku_ptr;

    doluluk_sonraki = doluluk_q;
    case ({yaz_ok, oku})
      2'b10:   doluluk_sonraki = doluluk_q + (AW + 1)'(1);
      2'b01:   doluluk_sonraki = doluluk_q - (AW + 1)'(1);
      default: doluluk_sonraki = doluluk_q;
    endcase

    // The head register is loaded with whatever will sit at the read pointer
    // after this edge. If that slot is being written now, take the incoming
    // word instead of the stale memory content.
    bas_sonraki = '0;
    if (doluluk_sonraki != '0) begin
      if (yaz_ok && (yaz_ptr == oku_ptr_sonraki))
        bas_sonraki = yaz_veri;
      else
        bas_sonraki = mem[oku_ptr_sonraki];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && yaz_ok)
      mem[yaz_ptr] <= yaz_veri;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bayt_idx   <= '0;
      toplama    <= '0;
      piksel_say <= '0;
      cerceve_q  <= 1'b0;
      tasma_q    <= 1'b0;
      yaz_ptr    <= '0;
      oku_ptr    <= '0;
      doluluk_q  <= '0;
      bas_q      <= '0;
    end else begin
      cerceve_q <= veri_etkin_i && son_piksel;

      if (veri_etkin_i) begin
        case (bayt_idx)
          2'd0:    toplama[7:0]   <= veri_i;
          2'd1:    toplama[15:8]  <= veri_i;
          2'd2:    toplama[23:16] <= veri_i;
          default: ;
        endcase
        bayt_idx <= bayt_idx + 2'd1;
        // Counts every pixel, dropped words included, to keep frame alignment.
        piksel_say <= son_piksel ? '0 : (piksel_say + CW'(1));
      end

      if (yaz && dolu && !oku)
        tasma_q <= 1'b1;

      if (yaz_ok)
        yaz_ptr <= yaz_ptr + AW'(1);
      oku_ptr   <= oku_ptr_sonraki;
      doluluk_q <= doluluk_sonraki;
      bas_q     <= bas_sonraki;
    end
  end

  assign paket_gecerli_o = (doluluk_q != '0);
  assign paket_o         = bas_q[31:0];
  assign paket_son_o     = bas_q[32];
  assign doluluk_o       = doluluk_q;
  assign tasma_o         = tasma_q;
  assign cerceve_bitti_o = cerceve_q;

endmodule

// File: tb/tb_piksel_paketleyici.sv
// Directed bench for piksel_paketleyici. A 32x8 frame (256 pixels) keeps the
// run short while pixel value = index mod 256 still ends on 0xFFFEFDFC.

module tb_piksel_paketleyici;

  localparam int G  = 32;
  localparam int Y  = 8;
  localparam int D  = 16;
  localparam int FR = G * Y;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        veri_etkin_i = 1'b0;
  logic [7:0]  veri_i = '0;
  logic        paket_gecerli_o;
  logic [31:0] paket_o;
  logic        paket_son_o;
  logic        paket_hazir_i = 1'b0;
  logic [4:0]  doluluk_o;
  logic        tasma_o;
  logic        cerceve_bitti_o;

  piksel_paketleyici #(.GENISLIK(G), .YUKSEKLIK(Y), .FIFO_DERINLIK(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .veri_etkin_i(veri_etkin_i), .veri_i(veri_i),
    .paket_gecerli_o(paket_gecerli_o), .paket_o(paket_o), .paket_son_o(paket_son_o),
    .paket_hazir_i(paket_hazir_i), .doluluk_o(doluluk_o), .tasma_o(tasma_o),
    .cerceve_bitti_o(cerceve_bitti_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [31:0] rx_q[$];
  bit          rx_son_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record a transfer decided at this edge, then settle past it.
  task automatic cyc();
    if (paket_gecerli_o && paket_hazir_i) begin
      rx_q.push_back(paket_o);
      rx_son_q.push_back(paket_son_o);
    end
    @(posedge clk_i);
    #1;
    if (cerceve_bitti_o) pulses++;
  endtask

  task automatic pix(input logic [7:0] v);
    veri_etkin_i = 1'b1;
    veri_i = v;
    cyc();
    veri_etkin_i = 1'b0;
  endtask

  task automatic drain();
    veri_etkin_i = 1'b0;
    paket_hazir_i = 1'b1;
    for (int i = 0; i < 40 && paket_gecerli_o; i++) cyc();
    chk("drain_done", 64'(paket_gecerli_o), 64'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    veri_etkin_i = 1'b0;
    cyc();
    rst_i = 1'b0;
    rx_q.delete();
    rx_son_q.delete();
    pulses = 0;
  endtask

  function automatic int son_count();
    int n = 0;
    foreach (rx_son_q[i]) if (rx_son_q[i]) n++;
    return n;
  endfunction

  initial begin
    int viol, bad, maxd;
    logic        stall;
    logic [31:0] pw;
    logic [31:0] ew;

    // Reset state
    do_reset();
    chk("rst_valid", 64'(paket_gecerli_o), 64'd0);
    chk("rst_data", 64'(paket_o), 64'd0);
    chk("rst_son", 64'(paket_son_o), 64'd0);
    chk("rst_count", 64'(doluluk_o), 64'd0);
    chk("rst_ovf", 64'(tasma_o), 64'd0);
    chk("rst_frame", 64'(cerceve_bitti_o), 64'd0);

    // Single word, ready high
    paket_hazir_i = 1'b1;
    pix(8'h11); pix(8'h22); pix(8'h33);
    chk("w1_not_yet", 64'(paket_gecerli_o), 64'd0);
    pix(8'h44);
    chk("w1_valid", 64'(paket_gecerli_o), 64'd1);
    chk("w1_data", 64'(paket_o), 64'h44332211);
    chk("w1_son", 64'(paket_son_o), 64'd0);
    chk("w1_count", 64'(doluluk_o), 64'd1);
    cyc();
    chk("w1_popped", 64'(doluluk_o), 64'd0);
    chk("w1_rx", 64'(rx_q[0]), 64'h44332211);

    // Overflow: 68 pixels with ready low
    rx_q.delete(); rx_son_q.delete();
    paket_hazir_i = 1'b0;
    for (int i = 0; i < 68; i++) begin
      pix(8'(i));
      if (i == 63) begin
        chk("ovf_full16", 64'(doluluk_o), 64'd16);
        chk("ovf_not_yet", 64'(tasma_o), 64'd0);
      end
      if (i == 67) begin
        chk("ovf_flag", 64'(tasma_o), 64'd1);
        chk("ovf_count", 64'(doluluk_o), 64'd16);
      end
    end
    drain();
    chk("ovf_words", 64'(rx_q.size()), 64'd16);
    chk("ovf_first", 64'(rx_q[0]), 64'h03020100);
    chk("ovf_last", 64'(rx_q[$]), 64'h3F3E3D3C);
    chk("ovf_sticky", 64'(tasma_o), 64'd1);

    // Full frame, ready high
    do_reset();
    chk("frm_ovf_clr", 64'(tasma_o), 64'd0);
    paket_hazir_i = 1'b1;
    for (int i = 0; i < FR; i++) pix(8'(i));
    chk("frm_pulse", 64'(cerceve_bitti_o), 64'd1);
    cyc();
    chk("frm_pulse_end", 64'(cerceve_bitti_o), 64'd0);
    drain();
    chk("frm_words", 64'(rx_q.size()), 64'(FR / 4));
    chk("frm_last", 64'(rx_q[$]), 64'hFFFEFDFC);
    chk("frm_last_son", 64'(rx_son_q[$]), 64'd1);
    chk("frm_son_count", 64'(son_count()), 64'd1);
    chk("frm_pulses", 64'(pulses), 64'd1);
    chk("frm_no_ovf", 64'(tasma_o), 64'd0);

    // Random ready, continuous input
    do_reset();
    viol = 0; maxd = 0;
    for (int i = 0; i < 200; i++) begin
      paket_hazir_i = ($urandom_range(0, 3) != 0);
      veri_etkin_i = 1'b1;
      veri_i = 8'(i);
      stall = paket_gecerli_o && !paket_hazir_i;
      pw = paket_o;
      cyc();
      if (stall && (!paket_gecerli_o || paket_o !== pw)) viol++;
      if (int'(doluluk_o) > maxd) maxd = int'(doluluk_o);
    end
    veri_etkin_i = 1'b0;
    drain();
    chk("rnd_stable", 64'(viol), 64'd0);
    chk("rnd_notfull", 64'(maxd < D), 64'd1);
    chk("rnd_words", 64'(rx_q.size()), 64'd50);
    bad = 0;
    foreach (rx_q[k]) begin
      ew = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      if (rx_q[k] !== ew || rx_son_q[k]) bad++;
    end
    chk("rnd_data", 64'(bad), 64'd0);
    chk("rnd_no_ovf", 64'(tasma_o), 64'd0);

    // Full FIFO, push and pop on the same edge
    do_reset();
    paket_hazir_i = 1'b0;
    for (int i = 0; i < 67; i++) pix(8'(i));
    chk("fp_full", 64'(doluluk_o), 64'd16);
    paket_hazir_i = 1'b1;
    pix(8'd67);
    chk("fp_count", 64'(doluluk_o), 64'd16);
    chk("fp_no_ovf", 64'(tasma_o), 64'd0);
    drain();
    chk("fp_words", 64'(rx_q.size()), 64'd17);
    chk("fp_first", 64'(rx_q[0]), 64'h03020100);
    chk("fp_second", 64'(rx_q[1]), 64'h07060504);
    chk("fp_last", 64'(rx_q[$]), 64'h43424140);

    // Reset mid-operation
    do_reset();
    paket_hazir_i = 1'b0;
    pix(8'h01); pix(8'h02); pix(8'h03); pix(8'h04);
    pix(8'hAA); pix(8'hBB);
    chk("mr_pre_valid", 64'(paket_gecerli_o), 64'd1);
    do_reset();
    chk("mr_valid", 64'(paket_gecerli_o), 64'd0);
    chk("mr_data", 64'(paket_o), 64'd0);
    chk("mr_count", 64'(doluluk_o), 64'd0);
    chk("mr_son", 64'(paket_son_o), 64'd0);
    paket_hazir_i = 1'b1;
    for (int i = 0; i < FR; i++) pix(8'(i + 1));
    drain();
    chk("mr_words", 64'(rx_q.size()), 64'(FR / 4));
    chk("mr_first", 64'(rx_q[0]), 64'h04030201);
    chk("mr_last", 64'(rx_q[$]), 64'h00FFFEFD);
    chk("mr_last_son", 64'(rx_son_q[$]), 64'd1);
    chk("mr_son_count", 64'(son_count()), 64'd1);
    chk("mr_pulses", 64'(pulses), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
